bist_sequencer: RTL and testbench

BIST_SEQUENCER -- requirements
Module: bist_sequencer

---
 rtl/bist_sequencer.sv | 135 +++++++++++++
 tb/tb_bist_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bist_sequencer.sv
// BIST session controller: seeds and runs the LFSR, flushes the MISR, then
// compares the captured signature against GOLDEN and keeps a saturating fail count.
module bist_sequencer #(
  parameter int unsigned PATTERNS = 7,
  parameter int unsigned FLUSH    = 1,
  parameter logic [3:0]  GOLDEN   = 4'b0011
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] misr_sig,
  output logic       testmode,
  output logic       lfsr_load,
  output logic       lfsr_en,
  output logic       misr_clr,
  output logic       misr_en,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fault_detected,
  output logic [3:0] sig_captured,
  output logic [7:0] fail_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_FLUSH,
    S_COMPARE,
    S_DONE
  } state_e;

  localparam logic [7:0] LAST_PAT   = 8'(PATTERNS - 1);
  localparam logic [7:0] LAST_FLUSH = (FLUSH > 0) ? 8'(FLUSH - 1) : 8'd0;

  state_e     state_q, state_d;
  logic [7:0] pat_cnt_q, pat_cnt_d;
  logic       pass_q, pass_d;
  logic       fault_q, fault_d;
  logic [3:0] sig_q, sig_d;
  logic [7:0] fail_cnt_q, fail_cnt_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pat_cnt_q  <= '0;
      pass_q     <= 1'b0;
      fault_q    <= 1'b0;
      sig_q      <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pat_cnt_q  <= pat_cnt_d;
      pass_q     <= pass_d;
      fault_q    <= fault_d;
      sig_q      <= sig_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pat_cnt_d  = pat_cnt_q;
    pass_d     = pass_q;
    fault_d    = fault_q;
    sig_d      = sig_q;
    fail_cnt_d = fail_cnt_q;
    if (abort) begin
      state_d   = S_IDLE;
      pat_cnt_d = '0;
      pass_d    = 1'b0;
      fault_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_INIT;
            pass_d  = 1'b0;
            fault_d = 1'b0;
          end
        end
        S_INIT: begin
          state_d   = S_RUN;
          pat_cnt_d = '0;
        end
        // pat_cnt is reused as the flush counter, so it restarts at 0 on leaving RUN
        S_RUN: begin
          if (pat_cnt_q == LAST_PAT) begin
            pat_cnt_d = '0;
            state_d   = (FLUSH > 0) ? S_FLUSH : S_COMPARE;
          end else begin
            pat_cnt_d = pat_cnt_q + 8'd1;
          end
        end
        S_FLUSH: begin
          if (pat_cnt_q == LAST_FLUSH) begin
            pat_cnt_d = '0;
            state_d   = S_COMPARE;
          end else begin
            pat_cnt_d = pat_cnt_q + 8'd1;
          end
        end
        S_COMPARE: begin
          sig_d   = misr_sig;
          pass_d  = (misr_sig == GOLDEN);
          fault_d = (misr_sig != GOLDEN);
          if ((misr_sig != GOLDEN) && (fail_cnt_q != 8'hFF)) begin
            fail_cnt_d = fail_cnt_q + 8'd1;
          end
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q == S_INIT) || (state_q == S_RUN) ||
                (state_q == S_FLUSH) || (state_q == S_COMPARE);
    testmode  = busy;
    lfsr_load = (state_q == S_INIT);
    misr_clr  = (state_q == S_INIT);
    lfsr_en   = (state_q == S_RUN);
    misr_en   = (state_q == S_RUN) || (state_q == S_FLUSH);
    done      = (state_q == S_DONE);
  end

  assign pass           = pass_q;
  assign fault_detected = fault_q;
  assign sig_captured   = sig_q;
  assign fail_count     = fail_cnt_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Bench for bist_sequencer: two instances (defaults and PATTERNS=1/FLUSH=0) share
// stimulus; each is compared every cycle against a session-timeline model.
module tb_bist_sequencer;

  localparam logic [3:0] GOOD = 4'b0011;
  localparam logic [3:0] BAD  = 4'b0101;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] misr_sig = '0;

  logic [1:0] tm, ll, le, mc, me, bz, dn, ps, fd;
  logic [3:0] sc [2];
  logic [7:0] fc [2];

  always #5 clock = ~clock;

  bist_sequencer #(.PATTERNS(7), .FLUSH(1), .GOLDEN(GOOD)) u0 (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .misr_sig(misr_sig),
    .testmode(tm[0]), .lfsr_load(ll[0]), .lfsr_en(le[0]), .misr_clr(mc[0]),
    .misr_en(me[0]), .busy(bz[0]), .done(dn[0]), .pass(ps[0]),
    .fault_detected(fd[0]), .sig_captured(sc[0]), .fail_count(fc[0])
  );

  bist_sequencer #(.PATTERNS(1), .FLUSH(0), .GOLDEN(GOOD)) u1 (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .misr_sig(misr_sig),
    .testmode(tm[1]), .lfsr_load(ll[1]), .lfsr_en(le[1]), .misr_clr(mc[1]),
    .misr_en(me[1]), .busy(bz[1]), .done(dn[1]), .pass(ps[1]),
    .fault_detected(fd[1]), .sig_captured(sc[1]), .fail_count(fc[1])
  );

  int checks = 0;
  int errors = 0;

  // Model: a session is a position counter (0 = init cycle) plus the held result.
  typedef struct {
    bit act;
    int pos;
    bit done;
    bit pass;
    bit fault;
    int sig;
    int fc;
  } mdl_t;

  mdl_t m [2];
  int   np [2] = '{7, 1};
  int   nf [2] = '{1, 0};

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void mdl_reset(input int i);
    m[i] = '{default: 0};
  endfunction

  function automatic void mdl_edge(input int i, input logic s, input logic a,
                                   input logic [3:0] ms);
    if (a) begin
      m[i].act = 0; m[i].done = 0; m[i].pass = 0; m[i].fault = 0;
    end else if (m[i].act) begin
      if (m[i].pos == np[i] + nf[i] + 1) begin
        m[i].act   = 0;
        m[i].done  = 1;
        m[i].sig   = int'(ms);
        m[i].pass  = (ms == GOOD);
        m[i].fault = (ms != GOOD);
        if (ms != GOOD && m[i].fc < 255) m[i].fc++;
      end else begin
        m[i].pos++;
      end
    end else if (s) begin
      m[i].act = 1; m[i].pos = 0; m[i].done = 0; m[i].pass = 0; m[i].fault = 0;
    end
  endfunction

  task automatic check_outs(input int i);
    bit act;
    int p;
    act = m[i].act;
    p   = m[i].pos;
    check_eq($sformatf("u%0d.busy", i), int'(bz[i]), int'(act));
    check_eq($sformatf("u%0d.testmode", i), int'(tm[i]), int'(act));
    check_eq($sformatf("u%0d.lfsr_load", i), int'(ll[i]), int'(act && p == 0));
    check_eq($sformatf("u%0d.misr_clr", i), int'(mc[i]), int'(act && p == 0));
    check_eq($sformatf("u%0d.lfsr_en", i), int'(le[i]), int'(act && p >= 1 && p <= np[i]));
    check_eq($sformatf("u%0d.misr_en", i), int'(me[i]),
             int'(act && p >= 1 && p <= np[i] + nf[i]));
    check_eq($sformatf("u%0d.done", i), int'(dn[i]), int'(m[i].done));
    check_eq($sformatf("u%0d.pass", i), int'(ps[i]), int'(m[i].pass));
    check_eq($sformatf("u%0d.fault", i), int'(fd[i]), int'(m[i].fault));
    check_eq($sformatf("u%0d.sig", i), int'(sc[i]), m[i].sig);
    check_eq($sformatf("u%0d.fail_count", i), int'(fc[i]), m[i].fc);
  endtask

  task automatic cycle(input logic s, input logic a, input logic [3:0] ms);
    start    = s;
    abort    = a;
    misr_sig = ms;
    @(posedge clock);
    for (int i = 0; i < 2; i++) begin
      if (reset) mdl_reset(i);
      else mdl_edge(i, s, a, ms);
    end
    #1;
    for (int i = 0; i < 2; i++) check_outs(i);
  endtask

  task automatic async_reset();
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      mdl_reset(i);
      check_outs(i);
    end
  endtask

  initial begin
    int done_at [2];
    int n_load, n_len, n_men;

    for (int i = 0; i < 2; i++) mdl_reset(i);
    #1;
    for (int i = 0; i < 2; i++) check_outs(i);
    cycle(1'b1, 1'b0, GOOD);
    cycle(1'b0, 1'b0, GOOD);
    reset = 1'b0;
    cycle(1'b0, 1'b0, GOOD);

    // Good session with latency and strobe-length measurement
    done_at = '{-1, -1};
    cycle(1'b1, 1'b0, GOOD);
    n_load = int'(ll[0]);
    n_len  = int'(le[0]);
    n_men  = int'(me[0]);
    for (int k = 1; k <= 14; k++) begin
      cycle(1'b0, 1'b0, GOOD);
      n_load += int'(ll[0]);
      n_len  += int'(le[0]);
      n_men  += int'(me[0]);
      for (int i = 0; i < 2; i++)
        if (dn[i] && done_at[i] < 0) done_at[i] = k;
    end
    check_eq("good.latency_u0", done_at[0], 7 + 1 + 2);
    check_eq("good.latency_u1", done_at[1], 1 + 0 + 2);
    check_eq("good.load_cycles", n_load, 1);
    check_eq("good.lfsr_en_cycles", n_len, 7);
    check_eq("good.misr_en_cycles", n_men, 8);
    check_eq("good.pass", int'(ps[0]), 1);
    check_eq("good.fault", int'(fd[0]), 0);
    check_eq("good.fail_count", int'(fc[0]), 0);

    // Faulty session
    cycle(1'b1, 1'b0, BAD);
    for (int k = 0; k < 12; k++) cycle(1'b0, 1'b0, BAD);
    check_eq("bad.sig", int'(sc[0]), int'(BAD));
    check_eq("bad.fault", int'(fd[0]), 1);
    check_eq("bad.pass", int'(ps[0]), 0);
    check_eq("bad.fail_count", int'(fc[0]), 1);

    // Abort on the 4th RUN cycle with start held high
    cycle(1'b1, 1'b0, GOOD);
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, GOOD);
    cycle(1'b1, 1'b1, GOOD);
    check_eq("abort.busy", int'(bz[0]), 0);
    check_eq("abort.done", int'(dn[0]), 0);
    check_eq("abort.testmode", int'(tm[0]), 0);
    check_eq("abort.fail_count", int'(fc[0]), 1);
    cycle(1'b1, 1'b1, GOOD);
    check_eq("abort_start_idle.busy", int'(bz[0]), 0);
    cycle(1'b0, 1'b0, GOOD);

    // Reset asserted mid-FLUSH, checked before any clock edge
    cycle(1'b1, 1'b0, GOOD);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, GOOD);
    check_eq("flush.misr_en", int'(me[0]), 1);
    check_eq("flush.lfsr_en", int'(le[0]), 0);
    async_reset();
    check_eq("rst.fail_count", int'(fc[0]), 0);
    check_eq("rst.busy", int'(bz[0]), 0);
    cycle(1'b0, 1'b0, GOOD);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, GOOD);
    check_eq("rst.no_restart", int'(bz[0]), 0);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      logic [3:0] ms;
      ms = ($urandom_range(0, 1) == 0) ? GOOD : 4'($urandom);
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 31) == 0), ms);
    end

    // Back-to-back failing sessions up to saturation
    async_reset();
    cycle(1'b0, 1'b0, BAD);
    reset = 1'b0;
    for (int k = 0; k < 256 * 11 + 4; k++) cycle(1'b1, 1'b0, BAD);
    check_eq("sat.u0", int'(fc[0]), 255);
    check_eq("sat.u1", int'(fc[1]), 255);
    for (int k = 0; k < 40; k++) cycle(1'b1, 1'b0, BAD);
    check_eq("sat_hold.u0", int'(fc[0]), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
